// File: rtl/usb_pkg.sv
// Shared types and constants for the USB device transaction sequencer.
package usb_pkg;

    typedef enum logic [2:0] {
        PID_NONE  = 3'd0,
        PID_OUT   = 3'd1,
        PID_IN    = 3'd2,
        PID_DATA0 = 3'd3,
        PID_DATA1 = 3'd4,
        PID_ACK   = 3'd5,
        PID_NAK   = 3'd6,
        PID_STALL = 3'd7
    } pid_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OUT_WAIT,
        ST_SEND,
        ST_TX_BUSY,
        ST_IN_WAIT_ACK
    } xfer_state_t;

    // Terminal count of the response timer: last count value before timeout fires.
    function automatic int timeout_cycles(input int clks_per_bit, input int timeout_bits);
        return clks_per_bit * timeout_bits - 1;
    endfunction

endpackage

// File: rtl/usb_xfer_timer.sv
// Response timer: counts clk cycles while enabled, saturates at terminal count.
module usb_xfer_timer
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int TIMEOUT_BITS = 18
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int TC = timeout_cycles(CLKS_PER_BIT, TIMEOUT_BITS);
    localparam int W  = $clog2(TC) + 1;

    logic [W-1:0] count;

    assign timeout = (count == W'(TC));

    // Counter holds at terminal count so a deferred timeout is not lost.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !timeout) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/usb_xfer_ctrl.sv
// Device-side transaction sequencer: token/data decode, handshake responses,
// DATA0/DATA1 toggle tracking and data buffer arbitration.
module usb_xfer_ctrl
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int TIMEOUT_BITS = 18
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] rx_packet,
    input  logic       rx_data_ready,
    input  logic       rx_transfer_active,
    input  logic       rx_error,
    input  logic       tx_transfer_active,
    input  logic       tx_error,
    input  logic [6:0] buffer_occupancy,
    input  logic       host_tx_loaded,
    input  logic       host_rx_taken,
    output logic [2:0] tx_packet,
    output logic       tx_start,
    output logic       d_mode,
    output logic       store_inhibit,
    output logic       flush,
    output logic       rx_data_avail,
    output logic       tx_done,
    output logic       xfer_error
);

    xfer_state_t state, state_next;
    logic tx_tgl, tx_tgl_next, rx_tgl, rx_tgl_next;
    logic nak_pend, nak_pend_next, flush_pend, flush_pend_next;
    logic tx_active_q;
    logic [2:0] tx_packet_next;
    logic tx_start_next, d_mode_next, store_inhibit_next, flush_next;
    logic rx_data_avail_next, tx_done_next, xfer_error_next;
    logic flush_req, avail_set, timer_timeout;

    pid_t rx_pid;
    logic pkt_ok, is_data, tx_fall, timeout, sent_data, busy_out;

    assign rx_pid    = pid_t'(rx_packet);
    assign pkt_ok    = rx_data_ready & ~rx_error;
    assign is_data   = (rx_pid == PID_DATA0) || (rx_pid == PID_DATA1);
    assign tx_fall   = tx_active_q & ~tx_transfer_active;
    // A timeout is held off while a packet is still arriving.
    assign timeout   = timer_timeout & ~rx_transfer_active;
    assign sent_data = (tx_packet == PID_DATA0) || (tx_packet == PID_DATA1);
    assign busy_out  = rx_data_avail | host_tx_loaded;

    usb_xfer_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) u_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (state_next != state),
        .enable ((state == ST_OUT_WAIT) || (state == ST_IN_WAIT_ACK)),
        .timeout(timer_timeout)
    );

    // Next-state, toggle and registered-output decode.
    always_comb begin
        state_next         = state;
        tx_tgl_next        = tx_tgl;
        rx_tgl_next        = rx_tgl;
        nak_pend_next      = nak_pend;
        tx_packet_next     = tx_packet;
        tx_start_next      = 1'b0;
        d_mode_next        = d_mode;
        store_inhibit_next = store_inhibit;
        tx_done_next       = 1'b0;
        xfer_error_next    = xfer_error;
        flush_req          = 1'b0;
        avail_set          = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pkt_ok && rx_pid == PID_OUT) begin
                    xfer_error_next    = 1'b0;
                    nak_pend_next      = busy_out;
                    store_inhibit_next = busy_out;
                    state_next         = ST_OUT_WAIT;
                end else if (pkt_ok && rx_pid == PID_IN) begin
                    xfer_error_next = 1'b0;
                    if (host_tx_loaded && buffer_occupancy != 7'd0)
                        tx_packet_next = tx_tgl ? PID_DATA1 : PID_DATA0;
                    else
                        tx_packet_next = PID_NAK;
                    state_next = ST_SEND;
                end
            end
            ST_OUT_WAIT: begin
                if (rx_data_ready && is_data) begin
                    if (rx_error) begin
                        flush_req          = 1'b1;
                        xfer_error_next    = 1'b1;
                        store_inhibit_next = 1'b0;
                        state_next         = ST_IDLE;
                    end else if (nak_pend) begin
                        tx_packet_next     = PID_NAK;
                        store_inhibit_next = 1'b0;
                        state_next         = ST_SEND;
                    end else if ((rx_pid == PID_DATA1) == rx_tgl) begin
                        tx_packet_next = PID_ACK;
                        avail_set      = 1'b1;
                        rx_tgl_next    = ~rx_tgl;
                        state_next     = ST_SEND;
                    end else begin
                        // Host retried a packet we already accepted: ACK it, drop the copy.
                        tx_packet_next = PID_ACK;
                        flush_req      = 1'b1;
                        state_next     = ST_SEND;
                    end
                end else if (timeout) begin
                    flush_req          = ~nak_pend;
                    xfer_error_next    = 1'b1;
                    store_inhibit_next = 1'b0;
                    state_next         = ST_IDLE;
                end
            end
            ST_SEND: begin
                tx_start_next = 1'b1;
                d_mode_next   = 1'b1;
                state_next    = ST_TX_BUSY;
            end
            ST_TX_BUSY: begin
                if (tx_error) begin
                    xfer_error_next = 1'b1;
                    d_mode_next     = 1'b0;
                    state_next      = ST_IDLE;
                end else if (tx_fall) begin
                    d_mode_next = 1'b0;
                    state_next  = sent_data ? ST_IN_WAIT_ACK : ST_IDLE;
                end
            end
            ST_IN_WAIT_ACK: begin
                if (rx_data_ready) begin
                    if (pkt_ok && rx_pid == PID_ACK) begin
                        tx_tgl_next  = ~tx_tgl;
                        tx_done_next = 1'b1;
                        flush_req    = 1'b1;
                    end else begin
                        xfer_error_next = 1'b1;
                    end
                    state_next = ST_IDLE;
                end else if (timeout) begin
                    xfer_error_next = 1'b1;
                    state_next      = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Host read completion frees the buffer, unless new data lands this same cycle.
        if (host_rx_taken && !avail_set)
            flush_req = 1'b1;
        rx_data_avail_next = avail_set ? 1'b1 : (host_rx_taken ? 1'b0 : rx_data_avail);

        // Flush is pushed one cycle past tx_start so the two never coincide.
        if (tx_start_next) begin
            flush_next      = 1'b0;
            flush_pend_next = flush_pend | flush_req;
        end else begin
            flush_next      = flush_pend | flush_req;
            flush_pend_next = 1'b0;
        end
    end

    // State, toggles and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= ST_IDLE;
            tx_tgl        <= 1'b0;
            rx_tgl        <= 1'b0;
            nak_pend      <= 1'b0;
            flush_pend    <= 1'b0;
            tx_active_q   <= 1'b0;
            tx_packet     <= 3'd0;
            tx_start      <= 1'b0;
            d_mode        <= 1'b0;
            store_inhibit <= 1'b0;
            flush         <= 1'b0;
            rx_data_avail <= 1'b0;
            tx_done       <= 1'b0;
            xfer_error    <= 1'b0;
        end else begin
            state         <= state_next;
            tx_tgl        <= tx_tgl_next;
            rx_tgl        <= rx_tgl_next;
            nak_pend      <= nak_pend_next;
            flush_pend    <= flush_pend_next;
            tx_active_q   <= tx_transfer_active;
            tx_packet     <= tx_packet_next;
            tx_start      <= tx_start_next;
            d_mode        <= d_mode_next;
            store_inhibit <= store_inhibit_next;
            flush         <= flush_next;
            rx_data_avail <= rx_data_avail_next;
            tx_done       <= tx_done_next;
            xfer_error    <= xfer_error_next;
        end
    end

endmodule

// File: tb/tb_usb_xfer_ctrl.sv
// Directed bench for usb_xfer_ctrl with an event-level reference model.
module tb_usb_xfer_ctrl;

    localparam int         TO_CYC = 8 * 18;
    localparam logic [2:0] P_OUT = 3'd1, P_IN = 3'd2, P_D0 = 3'd3, P_D1 = 3'd4;
    localparam logic [2:0] P_ACK = 3'd5, P_NAK = 3'd6;

    logic       clk = 1'b0, n_rst = 1'b0;
    logic [2:0] rx_packet = 3'd0;
    logic       rx_data_ready = 1'b0, rx_transfer_active = 1'b0, rx_error = 1'b0;
    logic       tx_transfer_active = 1'b0, tx_error = 1'b0;
    logic [6:0] buffer_occupancy = 7'd0;
    logic       host_tx_loaded = 1'b0, host_rx_taken = 1'b0;
    logic [2:0] tx_packet;
    logic       tx_start, d_mode, store_inhibit, flush, rx_data_avail, tx_done, xfer_error;

    int   n_cmp = 0, n_bad = 0;
    logic cmp_on = 1'b0;

    // Model: levels, expected pulses for the current cycle, toggles, pending response.
    logic       m_avail, m_err, m_inh, m_dmode, m_txs, m_flush, m_done, m_nak, m_rxtgl, m_txtgl;
    logic [2:0] m_pid, m_resp;
    int         tx_cd, m_wait, m_wcnt;  // m_wait: 0 none, 1 awaiting OUT data, 2 awaiting IN ack

    usb_xfer_ctrl dut (
        .clk(clk), .n_rst(n_rst), .rx_packet(rx_packet), .rx_data_ready(rx_data_ready),
        .rx_transfer_active(rx_transfer_active), .rx_error(rx_error),
        .tx_transfer_active(tx_transfer_active), .tx_error(tx_error),
        .buffer_occupancy(buffer_occupancy), .host_tx_loaded(host_tx_loaded),
        .host_rx_taken(host_rx_taken), .tx_packet(tx_packet), .tx_start(tx_start),
        .d_mode(d_mode), .store_inhibit(store_inhibit), .flush(flush),
        .rx_data_avail(rx_data_avail), .tx_done(tx_done), .xfer_error(xfer_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_avail = 0; m_err = 0; m_inh = 0; m_dmode = 0; m_txs = 0; m_flush = 0; m_done = 0;
        m_nak = 0; m_rxtgl = 0; m_txtgl = 0; m_pid = 0; m_resp = 0;
        tx_cd = 0; m_wait = 0; m_wcnt = 0;
    endtask

    // Advance one clock; apply time-driven model effects (response launch, timeouts).
    task automatic tick();
        @(posedge clk); #1;
        m_txs = 0; m_flush = 0; m_done = 0;
        if (tx_cd > 0) begin
            tx_cd--;
            if (tx_cd == 0) begin m_txs = 1; m_dmode = 1; m_pid = m_resp; end
        end
        if (m_wait != 0) begin
            m_wcnt++;
            if (m_wcnt == TO_CYC) begin
                m_err = 1;
                if (m_wait == 1) begin
                    if (!m_nak) m_flush = 1;
                    m_inh = 0;
                end
                m_wait = 0;
            end
        end
    endtask

    // Deliver one received packet and apply the protocol rules to the model.
    task automatic pkt(input logic [2:0] pid, input logic err);
        rx_packet = pid; rx_error = err; rx_data_ready = 1;
        tick();
        rx_packet = 0; rx_error = 0; rx_data_ready = 0;
        if (m_wait == 1 && (pid == P_D0 || pid == P_D1)) begin
            m_wait = 0;
            if (err) begin
                m_flush = 1; m_err = 1; m_inh = 0;
            end else if (m_nak) begin
                m_resp = P_NAK; m_inh = 0; tx_cd = 1;
            end else if ((pid == P_D1) == m_rxtgl) begin
                m_resp = P_ACK; m_avail = 1; m_rxtgl = ~m_rxtgl; tx_cd = 1;
            end else begin
                m_resp = P_ACK; m_flush = 1; tx_cd = 1;
            end
        end else if (m_wait == 2) begin
            m_wait = 0;
            if (!err && pid == P_ACK) begin
                m_txtgl = ~m_txtgl; m_done = 1; m_flush = 1;
            end else m_err = 1;
        end else if (m_wait == 0 && !err && pid == P_OUT) begin
            m_err = 0; m_nak = m_avail | host_tx_loaded; m_inh = m_nak;
            m_wait = 1; m_wcnt = 0;
        end else if (m_wait == 0 && !err && pid == P_IN) begin
            m_err = 0;
            m_resp = (host_tx_loaded && buffer_occupancy != 0) ? (m_txtgl ? P_D1 : P_D0) : P_NAK;
            tx_cd = 1;
        end
    endtask

    // Launch of the scheduled response, then a usb_tx busy window ending in a fall.
    task automatic tx_run(input logic [2:0] lit);
        tick();
        chk("lit_tx_packet", 8'(tx_packet), 8'(lit));
        tx_transfer_active = 1;
        repeat (3) tick();
        tx_transfer_active = 0;
        tick();
        m_dmode = 0;
        if (m_resp == P_D0 || m_resp == P_D1) begin m_wait = 2; m_wcnt = 0; end
    endtask

    task automatic host_taken();
        host_rx_taken = 1;
        tick();
        host_rx_taken = 0;
        m_avail = 0; m_flush = 1;
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("rx_data_avail", 8'(rx_data_avail), 8'(m_avail));
            chk("xfer_error", 8'(xfer_error), 8'(m_err));
            chk("store_inhibit", 8'(store_inhibit), 8'(m_inh));
            chk("d_mode", 8'(d_mode), 8'(m_dmode));
            chk("tx_start", 8'(tx_start), 8'(m_txs));
            chk("flush", 8'(flush), 8'(m_flush));
            chk("tx_done", 8'(tx_done), 8'(m_done));
            chk("start_flush_overlap", 8'(tx_start & flush), 8'd0);
            if (m_txs) chk("tx_packet", 8'(tx_packet), 8'(m_pid));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tx_packet"}, 8'(tx_packet), 8'd0);
        chk({tag, "_tx_start"}, 8'(tx_start), 8'd0);
        chk({tag, "_d_mode"}, 8'(d_mode), 8'd0);
        chk({tag, "_store_inhibit"}, 8'(store_inhibit), 8'd0);
        chk({tag, "_flush"}, 8'(flush), 8'd0);
        chk({tag, "_rx_data_avail"}, 8'(rx_data_avail), 8'd0);
        chk({tag, "_tx_done"}, 8'(tx_done), 8'd0);
        chk({tag, "_xfer_error"}, 8'(xfer_error), 8'd0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk) n_rst = 1;
        tick();
        cmp_on = 1;

        // 1: OUT + DATA0 accepted -> ACK, data available
        pkt(P_OUT, 0); pkt(P_D0, 0); tx_run(P_ACK);
        chk("lit_avail_after_out", 8'(rx_data_avail), 8'd1);
        repeat (2) tick();

        // 2: host reads, host retries DATA0 -> ACK + flush, avail stays 0
        host_taken(); tick();
        pkt(P_OUT, 0); pkt(P_D0, 0); tx_run(P_ACK);
        chk("lit_avail_after_dup", 8'(rx_data_avail), 8'd0);

        // 3: IN with payload -> DATA0, ACKed; next IN -> DATA1, no ACK -> timeout; retry
        host_tx_loaded = 1; buffer_occupancy = 7'd10;
        pkt(P_IN, 0); tx_run(P_D0); tick(); pkt(P_ACK, 0); tick();
        pkt(P_IN, 0); tx_run(P_D1);
        repeat (TO_CYC - 1) tick();
        chk("lit_err_before_timeout", 8'(xfer_error), 8'd0);
        tick();
        chk("lit_err_at_timeout", 8'(xfer_error), 8'd1);
        repeat (3) tick();
        pkt(P_IN, 0); tx_run(P_D1); pkt(P_ACK, 0); tick();

        // 4: IN without payload -> NAK; ignored packets; OUT timeout flushes
        host_tx_loaded = 0; buffer_occupancy = 7'd0;
        pkt(P_IN, 0); tx_run(P_NAK);
        pkt(P_IN, 1); tick(); pkt(P_ACK, 0); repeat (3) tick();
        pkt(P_OUT, 0); repeat (TO_CYC + 4) tick();

        // 5: corrupt DATA1 -> flush + error, no response; next IN clears error
        pkt(P_OUT, 0); pkt(P_D1, 1); repeat (4) tick();
        pkt(P_IN, 0); tx_run(P_NAK);
        chk("lit_err_cleared", 8'(xfer_error), 8'd0);

        // 6: OUT while data pending -> inhibit, NAK, no flush; reset mid-transmit
        pkt(P_OUT, 0); pkt(P_D1, 0); tx_run(P_ACK); tick();
        pkt(P_OUT, 0); tick(); pkt(P_D0, 0);
        tick();
        chk("lit_nak", 8'(tx_packet), 8'(P_NAK));
        tx_transfer_active = 1; tick(); tick();
        cmp_on = 0;
        #2 n_rst = 0;
        #1 chk_all_zero("async_reset");
        tx_transfer_active = 0;
        @(negedge clk) n_rst = 1;
        model_reset();
        tick();
        cmp_on = 1;

        // Toggles return to zero after reset
        host_tx_loaded = 1; buffer_occupancy = 7'd4;
        pkt(P_IN, 0); tx_run(P_D0); pkt(P_ACK, 0); repeat (3) tick();

        cmp_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
